// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit result inputs and the common-data-bus
// broadcast outputs. The "master" side is the set of FUs plus the bus
// consumers; the "slave" side is the arbiter itself.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 5,
  parameter int DW     = 32,
  parameter int TW     = 8
);
  logic [NUM_FU-1:0]    fu_finish;
  logic [NUM_FU*DW-1:0] fu_data;
  logic [NUM_FU*TW-1:0] fu_tag;
  logic [NUM_FU*DW-1:0] fu_pc;
  logic [NUM_FU-1:0]    fu_hold;
  logic                 cdb_valid;
  logic [TW-1:0]        cdb_rs_num;
  logic [DW-1:0]        cdb_data;
  logic [DW-1:0]        cdb_pc;
  logic [NUM_FU-1:0]    cdb_grant;
  logic                 overflow_err;

  modport master (
    output fu_finish, fu_data, fu_tag, fu_pc,
    input  fu_hold, cdb_valid, cdb_rs_num, cdb_data, cdb_pc, cdb_grant, overflow_err
  );

  modport slave (
    input  fu_finish, fu_data, fu_tag, fu_pc,
    output fu_hold, cdb_valid, cdb_rs_num, cdb_data, cdb_pc, cdb_grant, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result slot per functional unit, fixed
// priority (index 0 highest) with promotion of slots that have waited
// STARVE_LIMIT cycles. Grant and broadcast are combinational from the
// registered slots, so a result lands on the bus one cycle after capture.
module cdb_arbiter #(
  parameter int NUM_FU       = 5,
  parameter int DW           = 32,
  parameter int TW           = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  cdb_arbiter_if.slave   bus
);

  // A limit above 15 can never be reached by the 4-bit counter; clamp it to
  // 16 so the compare below simply never fires in that case.
  localparam int             LIM_SAT = (STARVE_LIMIT > 16) ? 16 : STARVE_LIMIT;
  localparam logic [4:0]     LIMIT   = 5'(LIM_SAT);
  localparam logic [NUM_FU-1:0] ONE  = NUM_FU'(1);

  logic [NUM_FU-1:0] r_valid;
  logic [DW-1:0]     r_data [NUM_FU];
  logic [TW-1:0]     r_tag  [NUM_FU];
  logic [DW-1:0]     r_pc   [NUM_FU];
  logic [3:0]        r_wait [NUM_FU];
  logic              r_ovf;

  logic [NUM_FU-1:0] w_starved;
  logic [NUM_FU-1:0] w_pick;
  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_drop;
  logic [DW-1:0]     w_data;
  logic [TW-1:0]     w_tag;
  logic [DW-1:0]     w_pc;

  // Flag valid slots whose wait counter has reached the promotion limit.
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_starved[i] = r_valid[i] && ({1'b0, r_wait[i]} >= LIMIT);
    end
  end

  // Starved slots take precedence over plain valid ones; within the chosen
  // set the lowest index wins (isolate the least-significant set bit).
  always_comb begin
    w_pick  = (|w_starved) ? w_starved : r_valid;
    w_grant = w_pick & (~w_pick + ONE);
  end

  // Broadcast mux: OR of the one-hot selected slot, zero when idle.
  always_comb begin
    w_data = '0;
    w_tag  = '0;
    w_pc   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_grant[i]) begin
        w_data = w_data | r_data[i];
        w_tag  = w_tag  | r_tag[i];
        w_pc   = w_pc   | r_pc[i];
      end
    end
  end

  // A finish pulse into an occupied, non-granted slot is a protocol error.
  assign w_drop = bus.fu_finish & r_valid & ~w_grant;

  assign bus.cdb_valid    = |w_grant;
  assign bus.cdb_grant    = w_grant;
  assign bus.cdb_rs_num   = w_tag;
  assign bus.cdb_data     = w_data;
  assign bus.cdb_pc       = w_pc;
  assign bus.fu_hold      = r_valid & ~w_grant;
  assign bus.overflow_err = r_ovf;

  // Slot capture / release / aging and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
        r_pc[i]   <= '0;
        r_wait[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_finish[i] && (!r_valid[i] || w_grant[i])) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= bus.fu_data[i*DW +: DW];
          r_tag[i]   <= bus.fu_tag[i*TW +: TW];
          r_pc[i]    <= bus.fu_pc[i*DW +: DW];
          r_wait[i]  <= '0;
        end else if (w_grant[i]) begin
          r_valid[i] <= 1'b0;
          r_wait[i]  <= '0;
        end else if (r_valid[i] && (r_wait[i] != 4'hF)) begin
          r_wait[i]  <= r_wait[i] + 4'd1;
        end
      end
      if (|w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each stimulus step pushes the broadcasts
// it should cause (cycle, grant, tag, data, pc) into a queue; every cycle the
// bus is sampled on the falling edge and matched against the queue head.
module tb_cdb_arbiter;
  localparam int NUM_FU = 5;
  localparam int DW     = 32;
  localparam int TW     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .DW(DW), .TW(TW)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .DW(DW), .TW(TW), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  grant;
    logic [7:0]  tag;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t;

  task automatic check(input string name, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic expect_bc(input int c, input logic [4:0] g, input logic [7:0] tg,
                           input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.cyc = c; e.grant = g; e.tag = tg; e.data = d; e.pc = p;
    q.push_back(e);
  endtask

  task automatic fin(input int s, input logic [31:0] d, input logic [7:0] tg, input logic [31:0] p);
    bus.fu_finish[s]           = 1'b1;
    bus.fu_data[s*DW +: DW]    = d;
    bus.fu_tag[s*TW +: TW]     = tg;
    bus.fu_pc[s*DW +: DW]      = p;
  endtask

  // Sample the bus mid-cycle and match it against the expected broadcasts.
  task automatic look();
    exp_t e;
    @(negedge clk);
    if (bus.cdb_valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 80'(bus.cdb_valid), 80'd0);
      end else begin
        e = q.pop_front();
        check("bc_cycle", 80'(cyc), 80'(e.cyc));
        check("bc_grant", 80'(bus.cdb_grant), 80'(e.grant));
        check("bc_tag",   80'(bus.cdb_rs_num), 80'(e.tag));
        check("bc_data",  80'(bus.cdb_data), 80'(e.data));
        check("bc_pc",    80'(bus.cdb_pc), 80'(e.pc));
      end
    end else begin
      check("idle_zero", {3'b0, bus.cdb_grant, bus.cdb_rs_num, bus.cdb_data, bus.cdb_pc}, 80'd0);
      check("missing_bc", 80'((q.size() > 0) && (q[0].cyc <= cyc)), 80'd0);
    end
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    cyc++;
    bus.fu_finish = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.fu_finish = '0;
    bus.fu_data   = '0;
    bus.fu_tag    = '0;
    bus.fu_pc     = '0;

    // reset, with a finish pulse that must be discarded
    rst = 1'b0;
    cycle_end();
    fin(0, 32'hDEAD_BEEF, 8'h77, 32'h0000_0BAD);
    look();
    check("rst_hold", 80'(bus.fu_hold), 80'd0);
    check("rst_ovf", 80'(bus.overflow_err), 80'd0);
    cycle_end();
    rst = 1'b1;
    look();
    check("post_rst_hold", 80'(bus.fu_hold), 80'd0);
    check("post_rst_ovf", 80'(bus.overflow_err), 80'd0);
    cycle_end();
    look(); cycle_end();

    // single result, latency one cycle
    t = cyc;
    fin(0, 32'h1234_5678, 8'h03, 32'h0000_1000);
    expect_bc(t + 1, 5'b00001, 8'h03, 32'h1234_5678, 32'h0000_1000);
    look(); cycle_end();
    look(); cycle_end();
    look(); cycle_end();

    // three-way contention
    t = cyc;
    fin(0, 32'hAAAA_0000, 8'h10, 32'h0000_2000);
    fin(2, 32'hAAAA_0002, 8'h12, 32'h0000_2002);
    fin(4, 32'hAAAA_0004, 8'h14, 32'h0000_2004);
    expect_bc(t + 1, 5'b00001, 8'h10, 32'hAAAA_0000, 32'h0000_2000);
    expect_bc(t + 2, 5'b00100, 8'h12, 32'hAAAA_0002, 32'h0000_2002);
    expect_bc(t + 3, 5'b10000, 8'h14, 32'hAAAA_0004, 32'h0000_2004);
    look(); cycle_end();
    look(); check("cont_hold_t1", 80'(bus.fu_hold), 80'h14); cycle_end();
    look(); check("cont_hold_t2", 80'(bus.fu_hold), 80'h10); cycle_end();
    look(); check("cont_hold_t3", 80'(bus.fu_hold), 80'h00); cycle_end();
    look(); cycle_end();

    // starvation: slot 0 refilled every cycle, slot 4 (tag 0) must get in
    t = cyc;
    fin(0, 32'h5000, 8'h20, 32'h6000);
    fin(4, 32'h44,   8'h00, 32'h6400);
    expect_bc(t + 1, 5'b00001, 8'h20, 32'h5000, 32'h6000);
    look(); cycle_end();
    for (int k = 1; k <= 8; k++) begin
      fin(0, 32'h5000 + k, 8'h20, 32'h6000 + k);
      if (k <= 7) begin
        expect_bc(t + k + 1, 5'b00001, 8'h20, 32'h5000 + k, 32'h6000 + k);
      end else begin
        expect_bc(t + 9,  5'b10000, 8'h00, 32'h44,   32'h6400);
        expect_bc(t + 10, 5'b00001, 8'h20, 32'h5008, 32'h6008);
      end
      look(); cycle_end();
    end
    look(); check("starve_hold0", 80'(bus.fu_hold), 80'h01); cycle_end();
    look(); cycle_end();
    look(); check("starve_ovf", 80'(bus.overflow_err), 80'd0); cycle_end();

    // back-to-back refill of the granted slot
    t = cyc;
    fin(1, 32'hB0B0_0001, 8'h31, 32'h0000_3001);
    expect_bc(t + 1, 5'b00010, 8'h31, 32'hB0B0_0001, 32'h0000_3001);
    look(); cycle_end();
    fin(1, 32'hB0B0_0002, 8'h32, 32'h0000_3002);
    expect_bc(t + 2, 5'b00010, 8'h32, 32'hB0B0_0002, 32'h0000_3002);
    look(); cycle_end();
    look(); cycle_end();
    look(); check("refill_ovf", 80'(bus.overflow_err), 80'd0); cycle_end();

    // protocol violation: pulse into a held slot is dropped
    t = cyc;
    fin(0, 32'hC0C0_0000, 8'h40, 32'h0000_4000);
    fin(2, 32'hC0C0_0002, 8'h42, 32'h0000_4002);
    expect_bc(t + 1, 5'b00001, 8'h40, 32'hC0C0_0000, 32'h0000_4000);
    expect_bc(t + 2, 5'b00100, 8'h42, 32'hC0C0_0002, 32'h0000_4002);
    look(); cycle_end();
    fin(2, 32'hBAD0_0002, 8'h99, 32'h0000_BAD2);
    look();
    check("viol_hold", 80'(bus.fu_hold), 80'h04);
    check("viol_ovf_before", 80'(bus.overflow_err), 80'd0);
    cycle_end();
    look(); check("viol_ovf_set", 80'(bus.overflow_err), 80'd1); cycle_end();
    look(); check("viol_ovf_sticky", 80'(bus.overflow_err), 80'd1); cycle_end();

    // reset in the middle of contention drops everything pending
    t = cyc;
    fin(0, 32'hD0D0_0000, 8'h50, 32'h0000_5000);
    fin(1, 32'hD0D0_0001, 8'h51, 32'h0000_5001);
    fin(2, 32'hD0D0_0002, 8'h52, 32'h0000_5002);
    expect_bc(t + 1, 5'b00001, 8'h50, 32'hD0D0_0000, 32'h0000_5000);
    look(); cycle_end();
    rst = 1'b0;
    look(); check("mid_rst_hold_before", 80'(bus.fu_hold), 80'h06); cycle_end();
    rst = 1'b1;
    look();
    check("mid_rst_hold", 80'(bus.fu_hold), 80'd0);
    check("mid_rst_ovf", 80'(bus.overflow_err), 80'd0);
    cycle_end();
    look(); cycle_end();
    look(); cycle_end();
    check("queue_drained", 80'(q.size()), 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 5: number of functional-unit (FU) result sources; index 0 has the highest fixed priority (ALU, MEM, MUL, DIV, JUMP order).
REQ-002 Parameter DW, default 32: result and PC width.
REQ-003 Parameter TW, default 8: RS tag width; tag 0 means "no RS entry".
REQ-004 Parameter STARVE_LIMIT, default 8: wait cycles after which a pending slot is promoted.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-007 fu_finish  input  NUM_FU  per-FU one-cycle result-valid pulse.
REQ-008 fu_data  input  NUM_FU*DW  per-FU result; slice i is bits [i*DW +: DW].
REQ-009 fu_tag  input  NUM_FU*TW  per-FU destination RS tag.
REQ-010 fu_pc  input  NUM_FU*DW  per-FU instruction PC, used for debug and write-back trace.
REQ-011 fu_hold  output  NUM_FU  FU i must not pulse fu_finish[i] while fu_hold[i] is 1.
REQ-012 cdb_valid  output  1  broadcast valid this cycle.
REQ-013 cdb_rs_num  output  TW  broadcast tag.
REQ-014 cdb_data  output  DW  broadcast result.
REQ-015 cdb_pc  output  DW  broadcast PC.
REQ-016 cdb_grant  output  NUM_FU  one-hot: the slot being broadcast.
REQ-017 overflow_err  output  1  sticky protocol-violation flag.

Function
REQ-018 The block SHALL hold one slot per FU: valid, data, tag, pc, and a 4-bit saturating wait counter.
REQ-019 On fu_finish[i], slot i SHALL capture data, tag and pc when it is empty, or when it is granted in the same cycle (back-to-back refill); wait[i] SHALL then load 0.
REQ-020 On fu_finish[i] while slot i is valid and not granted, the input SHALL be dropped, the slot SHALL keep its contents, and overflow_err SHALL set.
REQ-021 Grant SHALL be combinational from slot state: if any valid slot has wait >= STARVE_LIMIT, the lowest-index such slot wins; otherwise the lowest-index valid slot wins.
REQ-022 Exactly one slot SHALL be granted per cycle when any slot is valid; none otherwise.
REQ-023 cdb_valid, cdb_rs_num, cdb_data and cdb_pc SHALL reflect the granted slot in the same cycle; when nothing is granted they SHALL be 0.
REQ-024 The granted slot SHALL clear at the clock edge unless it is refilled per REQ-019.
REQ-025 Each valid, non-granted slot SHALL increment its wait counter, saturating at 15.
REQ-026 fu_hold[i] SHALL equal slot_valid[i] AND NOT cdb_grant[i].
REQ-027 Latency: a finish pulse in cycle t SHALL be broadcast no earlier than cycle t+1; with no contention, exactly t+1.
REQ-028 A slot whose captured tag is 0 SHALL still be arbitrated and broadcast with cdb_valid=1 and cdb_rs_num=0.
REQ-029 Under full load, every slot SHALL be broadcast within NUM_FU*(STARVE_LIMIT+1) cycles of capture.

Reset
REQ-030 While rst=0 at a clock edge, all slot valids, wait counters and overflow_err SHALL clear, and slot data, tag and pc SHALL clear to 0.
REQ-031 During and after reset, all outputs SHALL be 0 until the first capture.
REQ-032 A fu_finish pulse in a reset cycle SHALL be discarded; reset mid-contention SHALL lose all pending results.

Verification
REQ-033 Single result: fu_finish=5'b00001, data 0x12345678, tag 0x03 at t -> at t+1 cdb_valid=1, rs_num=0x03, data=0x12345678, grant=5'b00001; at t+2 cdb_valid=0.
REQ-034 Contention: fu_finish=5'b10101 at t -> grants 00001, 00100, 10000 at t+1, t+2, t+3; fu_hold[4]=1 at t+1 and t+2.
REQ-035 Starvation: slot 4 pending while slot 0 refills every cycle (STARVE_LIMIT=8) -> slot 4 granted by t+9; slot 0 resumes on the next cycle.
REQ-036 Refill: slot 1 granted at t while fu_finish[1] pulses with new data at t -> new data broadcast at t+1 (no contention); overflow_err stays 0.
REQ-037 Violation: fu_finish[2] pulses while slot 2 is held behind slot 0 -> overflow_err=1 and stays 1; the original slot-2 data is still broadcast.
REQ-038 Reset: rst=0 for one edge with three slots pending -> next cycle cdb_valid=0, fu_hold=0, overflow_err=0.
